// File: rtl/camera_sched_pkg.sv
// Shared types and constants for the D8M frame-capture sequencer.
package camera_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      CAPTURE
   } sched_state_e;

   localparam logic MODE_SINGLE = 1'b0;
   localparam logic MODE_CONT   = 1'b1;

   localparam int unsigned CNT_W = 12;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/camera_frame_measure.sv
// Per-frame geometry check: saturating pixel/line counters and a sticky error flag.
module camera_frame_measure
   import camera_sched_pkg::*;
#(
   parameter int unsigned EXP_WIDTH  = 640,
   parameter int unsigned EXP_HEIGHT = 480
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic pix_i,
   input  logic line_end_i,
   input  logic frame_end_i,
   output logic err_o
);

   localparam logic [CNT_W-1:0] ExpW = CNT_W'(EXP_WIDTH);
   localparam logic [CNT_W-1:0] ExpH = CNT_W'(EXP_HEIGHT);

   logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
   logic [CNT_W-1:0] line_next;
   logic             err_q, err_d;
   logic             line_err;

   always_comb begin
      line_err  = line_end_i && (pix_cnt_q != ExpW);
      line_next = line_end_i ? sat_inc(line_cnt_q) : line_cnt_q;
      // A line end coinciding with the frame end is counted before the height check.
      err_o     = err_q | line_err | (frame_end_i && (line_next != ExpH));

      pix_cnt_d  = pix_cnt_q;
      line_cnt_d = line_next;
      err_d      = err_o;
      if (line_end_i) begin
         pix_cnt_d = '0;
      end else if (pix_i) begin
         pix_cnt_d = sat_inc(pix_cnt_q);
      end
      if (clear_i || frame_end_i) begin
         pix_cnt_d  = '0;
         line_cnt_d = '0;
         err_d      = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pix_cnt_q  <= '0;
         line_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         pix_cnt_q  <= pix_cnt_d;
         line_cnt_q <= line_cnt_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: rtl/camera_frame_sched.sv
// Frame-capture sequencer: gates whole sensor frames downstream with skip/continuous modes.
// Optional watchdog built when CAMERA_FRAME_SCHED_TIMEOUT_EN is defined.
module camera_frame_sched
   import camera_sched_pkg::*;
#(
   parameter int unsigned EXP_WIDTH      = 640,
   parameter int unsigned EXP_HEIGHT     = 480,
   parameter int unsigned TIMEOUT_CYCLES = 32'd16777216
) (
   input  logic        CAMERA_PIXCLK,
   input  logic        reset,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic        CMD_MODE,
   input  logic [3:0]  CMD_SKIP,
   input  logic        CMD_STOP,
   input  logic        CAMERA_FVAL,
   input  logic        CAMERA_LVAL,
   input  logic [11:0] CAMERA_D,
   output logic [11:0] OUT_DATA,
   output logic        OUT_VALID,
   output logic        OUT_SOF,
   output logic        OUT_EOF,
   output logic        BUSY,
   output logic        FRAME_DONE,
   output logic        FRAME_ERR,
   output logic        TIMEOUT,
   output logic [15:0] FRAME_CNT
);

   sched_state_e state_q, state_d;
   logic         mode_q, mode_d;
   logic [3:0]   skip_q, skip_d;
   logic [3:0]   skip_rem_q, skip_rem_d;
   logic         stop_q, stop_d;
   logic         sof_pend_q, sof_pend_d;
   logic         pre_fval_q, pre_lval_q;
   logic [11:0]  out_data_q, out_data_d;
   logic         out_valid_q, out_valid_d;
   logic         out_sof_q, out_sof_d;
   logic         out_eof_q, out_eof_d;
   logic         done_q, done_d;
   logic         ferr_q, ferr_d;
   logic [15:0]  frame_cnt_q, frame_cnt_d;

   logic rise, fall, line_end, pix_on;
   logic capture_cyc, sof_arm, timeout_hit;
   logic meas_err;

   assign rise     = CAMERA_FVAL & ~pre_fval_q;
   assign fall     = ~CAMERA_FVAL & pre_fval_q;
   assign line_end = ~CAMERA_LVAL & pre_lval_q;
   assign pix_on   = CAMERA_FVAL & CAMERA_LVAL;

   // The rise cycle that leaves ARMED already belongs to the captured frame.
   assign capture_cyc = (state_q == CAPTURE) ||
                        ((state_q == ARMED) && rise && !CMD_STOP && (skip_rem_q == '0));
   assign sof_arm     = sof_pend_q | (state_q == ARMED);

   camera_frame_measure #(
      .EXP_WIDTH (EXP_WIDTH),
      .EXP_HEIGHT(EXP_HEIGHT)
   ) u_measure (
      .clk_i      (CAMERA_PIXCLK),
      .rst_i      (reset),
      .clear_i    (~capture_cyc | timeout_hit),
      .pix_i      (pix_on & capture_cyc),
      .line_end_i (line_end & capture_cyc),
      .frame_end_i((state_q == CAPTURE) & fall),
      .err_o      (meas_err)
   );

`ifdef CAMERA_FRAME_SCHED_TIMEOUT_EN
   localparam logic [24:0] TimeoutLim = 25'(TIMEOUT_CYCLES);

   logic [23:0] wdog_q, wdog_d;
   logic [24:0] wdog_inc;
   logic        timeout_q;

   assign wdog_inc    = {1'b0, wdog_q} + 25'd1;
   assign timeout_hit = (state_q != IDLE) && !(rise || fall) && (wdog_inc == TimeoutLim);

   always_comb begin
      wdog_d = wdog_inc[23:0];
      if ((state_q == IDLE) || rise || fall || timeout_hit) begin
         wdog_d = '0;
      end
   end

   always_ff @(posedge CAMERA_PIXCLK) begin
      if (reset) begin
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdog_q    <= wdog_d;
         timeout_q <= timeout_hit;
      end
   end

   assign TIMEOUT = timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign TIMEOUT     = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      skip_d      = skip_q;
      skip_rem_d  = skip_rem_q;
      stop_d      = stop_q;
      sof_pend_d  = sof_pend_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_eof_d   = 1'b0;
      done_d      = 1'b0;
      ferr_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;

      if (capture_cyc) begin
         out_valid_d = pix_on;
         out_data_d  = CAMERA_D;
         out_sof_d   = pix_on & sof_arm;
         sof_pend_d  = sof_arm & ~pix_on;
      end

      unique case (state_q)
         IDLE: begin
            if (CMD_VALID) begin
               mode_d     = CMD_MODE;
               skip_d     = CMD_SKIP;
               skip_rem_d = CMD_SKIP;
               state_d    = ARMED;
            end
         end
         ARMED: begin
            if (CMD_STOP) begin
               state_d = IDLE;
            end else if (rise) begin
               if (skip_rem_q == '0) begin
                  state_d = CAPTURE;
               end else begin
                  skip_rem_d = skip_rem_q - 4'd1;
               end
            end
         end
         CAPTURE: begin
            if (CMD_STOP) begin
               stop_d = 1'b1;
            end
            if (fall) begin
               out_eof_d   = 1'b1;
               done_d      = 1'b1;
               ferr_d      = meas_err;
               frame_cnt_d = frame_cnt_q + 16'd1;
               stop_d      = 1'b0;
               sof_pend_d  = 1'b0;
               skip_rem_d  = skip_q;
               state_d     = ((mode_q == MODE_CONT) && !stop_q && !CMD_STOP) ? ARMED : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (timeout_hit) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         out_sof_d   = 1'b0;
         stop_d      = 1'b0;
         sof_pend_d  = 1'b0;
      end
   end

   always_ff @(posedge CAMERA_PIXCLK) begin
      if (reset) begin
         state_q     <= IDLE;
         mode_q      <= MODE_SINGLE;
         skip_q      <= '0;
         skip_rem_q  <= '0;
         stop_q      <= 1'b0;
         sof_pend_q  <= 1'b0;
         pre_fval_q  <= 1'b0;
         pre_lval_q  <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
         done_q      <= 1'b0;
         ferr_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         skip_q      <= skip_d;
         skip_rem_q  <= skip_rem_d;
         stop_q      <= stop_d;
         sof_pend_q  <= sof_pend_d;
         pre_fval_q  <= CAMERA_FVAL;
         pre_lval_q  <= CAMERA_LVAL;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_eof_q   <= out_eof_d;
         done_q      <= done_d;
         ferr_q      <= ferr_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign CMD_READY  = (state_q == IDLE);
   assign BUSY       = (state_q != IDLE);
   assign OUT_DATA   = out_data_q;
   assign OUT_VALID  = out_valid_q;
   assign OUT_SOF    = out_sof_q;
   assign OUT_EOF    = out_eof_q;
   assign FRAME_DONE = done_q;
   assign FRAME_ERR  = ferr_q;
   assign FRAME_CNT  = frame_cnt_q;

endmodule

// File: tb/tb_camera_frame_sched.sv
// Self-checking bench: random pixel data and geometry against a frame-level capture model.
module tb_camera_frame_sched;

   localparam int EW = 8;
   localparam int EH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0, cmd_mode = 1'b0, cmd_stop = 1'b0;
   logic [3:0]  cmd_skip = '0;
   logic        fval = 1'b0, lval = 1'b0;
   logic [11:0] cam_d = '0;
   logic        cmd_ready, out_valid, out_sof, out_eof, busy;
   logic        frame_done, frame_err, timeout;
   logic [11:0] out_data;
   logic [15:0] frame_cnt;

   always #5 clk = ~clk;

   camera_frame_sched #(
      .EXP_WIDTH     (EW),
      .EXP_HEIGHT    (EH),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .CAMERA_PIXCLK(clk),
      .reset        (reset),
      .CMD_VALID    (cmd_valid),
      .CMD_READY    (cmd_ready),
      .CMD_MODE     (cmd_mode),
      .CMD_SKIP     (cmd_skip),
      .CMD_STOP     (cmd_stop),
      .CAMERA_FVAL  (fval),
      .CAMERA_LVAL  (lval),
      .CAMERA_D     (cam_d),
      .OUT_DATA     (out_data),
      .OUT_VALID    (out_valid),
      .OUT_SOF      (out_sof),
      .OUT_EOF      (out_eof),
      .BUSY         (busy),
      .FRAME_DONE   (frame_done),
      .FRAME_ERR    (frame_err),
      .TIMEOUT      (timeout),
      .FRAME_CNT    (frame_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Frame-level model: armed/skip bookkeeping per command and per frame start.
   bit m_armed = 0, m_mode = 0;
   int m_skip = 0, m_skip_rem = 0;
   int m_cnt = 0, m_done = 0, m_err = 0;
   int geo[$];
   logic [11:0] exp_q[$];
   logic [11:0] got_q[$];

   int sof_cnt, eof_cnt, done_cnt, ferr_cnt, bad_sof, pulse_skew, to_cnt, in_frame_px;

   always @(negedge clk) begin
      if (out_sof) begin
         sof_cnt++;
         if (!out_valid || in_frame_px != 0) bad_sof++;
      end
      if (out_valid) begin
         got_q.push_back(out_data);
         in_frame_px++;
      end
      if (out_eof) begin
         eof_cnt++;
         in_frame_px = 0;
      end
      if (frame_done) done_cnt++;
      if (frame_err) ferr_cnt++;
      if ((out_eof != frame_done) || (frame_err && !frame_done)) pulse_skew++;
      if (timeout) to_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      got_q.delete();
      exp_q.delete();
      sof_cnt = 0; eof_cnt = 0; done_cnt = 0; ferr_cnt = 0;
      bad_sof = 0; pulse_skew = 0; to_cnt = 0; in_frame_px = 0;
      m_done = 0; m_err = 0;
   endtask

   function automatic bit model_rise();
      if (!m_armed) return 1'b0;
      if (m_skip_rem == 0) begin
         if (m_mode) m_skip_rem = m_skip;
         else m_armed = 1'b0;
         return 1'b1;
      end
      m_skip_rem--;
      return 1'b0;
   endfunction

   function automatic int stream_diff();
      int n = 0;
      if (got_q.size() != exp_q.size()) return -1;
      foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) n++;
      return n;
   endfunction

   task automatic cmd(input bit mode, input int skip);
      bit acc = 1'b0;
      cmd_valid = 1'b1;
      cmd_mode  = mode;
      cmd_skip  = 4'(skip);
      for (int i = 0; i < 200 && !acc; i++) begin
         acc = cmd_ready;
         step();
      end
      cmd_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL cmd_accept: ready=%0b, required accepted within 200 cycles", cmd_ready);
      end else begin
         m_armed = 1'b1; m_mode = mode; m_skip = skip; m_skip_rem = skip;
      end
   endtask

   // Drives one frame from geo[]; stop_line >= 0 raises CMD_STOP at that line.
   task automatic send_frame(input int stop_line);
      bit cap, bad;
      logic [11:0] px;
      fval = 1'b1;
      lval = 1'b0;
      cap  = model_rise();
      bad  = (geo.size() != EH);
      repeat ($urandom_range(1, 2)) step();
      foreach (geo[i]) begin
         if (i == stop_line) cmd_stop = 1'b1;
         if (geo[i] != EW) bad = 1'b1;
         for (int p = 0; p < geo[i]; p++) begin
            lval  = 1'b1;
            px    = 12'($urandom);
            cam_d = px;
            if (cap) exp_q.push_back(px);
            step();
         end
         lval = 1'b0;
         repeat ($urandom_range(1, 3)) step();
      end
      fval = 1'b0;
      repeat (4) step();
      if (cap) begin
         m_cnt++; m_done++;
         if (bad) m_err++;
      end
      if (stop_line >= 0) begin
         cmd_stop = 1'b0;
         m_armed  = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      step();
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %0b required 1", cmd_ready);
      end
      checks++;
      if ({busy, out_valid, out_sof, out_eof, frame_done, frame_err, timeout, out_data} !== '0)
      begin
         errors++;
         $display("FAIL reset_outputs: got busy=%0b v=%0b sof=%0b eof=%0b done=%0b err=%0b to=%0b d=%0h required all 0",
                  busy, out_valid, out_sof, out_eof, frame_done, frame_err, timeout, out_data);
      end
      checks++;
      if (frame_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt);
      end
   endtask

   task automatic test_single();
      clear_obs();
      geo = '{8, 8, 8, 8};
      cmd(1'b0, 0);
      send_frame(-1);
      send_frame(-1);
      checks++;
      if (got_q.size() != 32) begin
         errors++; $display("FAIL single_pixels: got %0d required 32", got_q.size());
      end
      checks++;
      if (stream_diff() != 0) begin
         errors++; $display("FAIL single_data: got %0d diffs required 0", stream_diff());
      end
      checks++;
      if (sof_cnt != 1 || bad_sof != 0) begin
         errors++; $display("FAIL single_sof: got %0d (%0d misplaced) required 1", sof_cnt, bad_sof);
      end
      checks++;
      if (done_cnt != 1 || eof_cnt != 1 || ferr_cnt != 0 || pulse_skew != 0) begin
         errors++;
         $display("FAIL single_status: got done=%0d eof=%0d err=%0d skew=%0d required 1 1 0 0",
                  done_cnt, eof_cnt, ferr_cnt, pulse_skew);
      end
      checks++;
      if (frame_cnt !== 16'(m_cnt) || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_end: got cnt=%0d ready=%0b required cnt=%0d ready=1",
                  frame_cnt, cmd_ready, m_cnt);
      end
   endtask

   task automatic test_continuous();
      int cnt0 = m_cnt;
      clear_obs();
      geo = '{8, 8, 8, 8};
      cmd(1'b1, 2);
      for (int f = 0; f < 6; f++) send_frame((f == 5) ? 2 : -1);
      checks++;
      if (done_cnt != 2 || m_done != 2) begin
         errors++; $display("FAIL cont_done: got %0d required 2", done_cnt);
      end
      checks++;
      if (stream_diff() != 0 || got_q.size() != 64) begin
         errors++; $display("FAIL cont_data: got %0d pixels required 64 matching", got_q.size());
      end
      checks++;
      if (frame_cnt !== 16'(cnt0 + 2)) begin
         errors++; $display("FAIL cont_frame_cnt: got %0d required %0d", frame_cnt, cnt0 + 2);
      end
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL cont_stop_idle: got ready=%0b busy=%0b required 1 0", cmd_ready, busy);
      end
   endtask

   task automatic test_mid_frame();
      clear_obs();
      geo = '{8, 8, 8, 8};
      fork
         send_frame(-1);
         begin
            repeat (6) step();
            cmd(1'b0, 0);
         end
      join
      send_frame(-1);
      checks++;
      if (done_cnt != 1 || sof_cnt != 1 || bad_sof != 0) begin
         errors++; $display("FAIL mid_frame_done: got done=%0d sof=%0d required 1 1", done_cnt, sof_cnt);
      end
      checks++;
      if (stream_diff() != 0 || got_q.size() != 32) begin
         errors++; $display("FAIL mid_frame_data: got %0d pixels required 32 matching", got_q.size());
      end
   endtask

   task automatic test_errors();
      clear_obs();
      geo = '{8, 7, 8, 8};
      cmd(1'b0, 0);
      send_frame(-1);
      geo = '{8, 8, 8, 8, 8};
      cmd(1'b0, 0);
      send_frame(-1);
      geo = '{8, 8, 8, 8};
      cmd(1'b0, 0);
      send_frame(-1);
      checks++;
      if (done_cnt != 3) begin
         errors++; $display("FAIL err_done: got %0d required 3", done_cnt);
      end
      checks++;
      if (ferr_cnt != 2 || m_err != 2 || pulse_skew != 0) begin
         errors++; $display("FAIL err_flags: got %0d (skew %0d) required 2", ferr_cnt, pulse_skew);
      end
      checks++;
      if (stream_diff() != 0) begin
         errors++; $display("FAIL err_data: got %0d diffs required 0", stream_diff());
      end
   endtask

   task automatic test_random();
      int skip = $urandom_range(0, 2);
      int cnt0 = m_cnt;
      clear_obs();
      cmd(1'b1, skip);
      for (int f = 0; f < 6; f++) begin
         int nl = ($urandom_range(0, 1) == 0) ? EH : $urandom_range(3, 5);
         geo.delete();
         for (int l = 0; l < nl; l++)
            geo.push_back(($urandom_range(0, 2) != 0) ? EW : $urandom_range(7, 9));
         send_frame(-1);
      end
      cmd_stop = 1'b1;
      step();
      cmd_stop = 1'b0;
      m_armed  = 1'b0;
      step();
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL rand_stop_armed: got ready=%0b required 1", cmd_ready);
      end
      checks++;
      if (done_cnt != m_done || ferr_cnt != m_err) begin
         errors++;
         $display("FAIL rand_status: got done=%0d err=%0d required done=%0d err=%0d (skip %0d)",
                  done_cnt, ferr_cnt, m_done, m_err, skip);
      end
      checks++;
      if (stream_diff() != 0 || sof_cnt != m_done || bad_sof != 0) begin
         errors++;
         $display("FAIL rand_data: got %0d pixels %0d sof required %0d pixels %0d sof",
                  got_q.size(), sof_cnt, exp_q.size(), m_done);
      end
      checks++;
      if (frame_cnt !== 16'(cnt0 + m_done)) begin
         errors++; $display("FAIL rand_frame_cnt: got %0d required %0d", frame_cnt, cnt0 + m_done);
      end
   endtask

   task automatic test_reset_mid();
      clear_obs();
      geo = '{8, 8, 8, 8};
      cmd(1'b0, 0);
      fork
         send_frame(-1);
         begin
            repeat (12) step();
            reset = 1'b1;
            step();
            checks++;
            if (cmd_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_eof !== 1'b0 ||
                frame_done !== 1'b0 || frame_cnt !== 16'd0) begin
               errors++;
               $display("FAIL reset_mid_outputs: got ready=%0b busy=%0b v=%0b eof=%0b done=%0b cnt=%0d required 1 0 0 0 0 0",
                        cmd_ready, busy, out_valid, out_eof, frame_done, frame_cnt);
            end
            reset = 1'b0;
         end
      join
      checks++;
      if (eof_cnt != 0 || done_cnt != 0) begin
         errors++; $display("FAIL reset_mid_no_eof: got eof=%0d done=%0d required 0 0", eof_cnt, done_cnt);
      end
      m_cnt   = 0;
      m_armed = 1'b0;
      clear_obs();
   endtask

   task automatic test_timeout();
      int early = 0;
      clear_obs();
      fval = 1'b0;
      cmd(1'b0, 0);
      for (int i = 1; i <= 100; i++) begin
         step();
         if (i < 100 && timeout) early++;
      end
`ifdef CAMERA_FRAME_SCHED_TIMEOUT_EN
      checks++;
      if (early != 0 || timeout !== 1'b1) begin
         errors++; $display("FAIL timeout_pulse: got early=%0d at100=%0b required 0 1", early, timeout);
      end
      checks++;
      if (cmd_ready !== 1'b1 || frame_done !== 1'b0) begin
         errors++; $display("FAIL timeout_idle: got ready=%0b done=%0b required 1 0", cmd_ready, frame_done);
      end
      step();
      checks++;
      if (timeout !== 1'b0) begin
         errors++; $display("FAIL timeout_one_cycle: got %0b required 0", timeout);
      end
`else
      checks++;
      if (early != 0 || timeout !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL no_watchdog: got to=%0b busy=%0b required 0 1", timeout, busy);
      end
      cmd_stop = 1'b1;
      step();
      cmd_stop = 1'b0;
      step();
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL armed_stop: got ready=%0b required 1", cmd_ready);
      end
`endif
      m_armed = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_continuous();
      test_mid_frame();
      test_errors();
      test_random();
      test_reset_mid();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/camera_frame_sched.md
# camera_frame_sched

Frame-capture sequencer for the D8M camera path. It runs on the pixel clock beside the Bayer capture stage and takes commands from the host-side control logic. It gates whole frames from the raw sensor stream to the downstream VIP pipeline, and it handles single-shot and continuous modes with a frame-skip count. It also checks every captured frame's geometry against expected dimensions and reports done, error and timeout status.

## Interface
- EXP_WIDTH, 640: expected pixels per line (1..4095)
- EXP_HEIGHT, 480: expected lines per frame (1..4095)
- TIMEOUT_CYCLES, 2^24: watchdog limit in pixel clocks (used only with the timeout macro)
- CAMERA_PIXCLK  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  high only in IDLE
- CMD_MODE  in  1  0 = single frame, 1 = continuous
- CMD_SKIP  in  4  frames to discard before each capture
- CMD_STOP  in  1  abort/stop level, sampled every cycle
- CAMERA_FVAL, CAMERA_LVAL  in  1 each  raw sensor syncs
- CAMERA_D  in  12  raw sensor pixel
- OUT_DATA  out  12  gated pixel
- OUT_VALID  out  1  gated pixel valid
- OUT_SOF  out  1  with the first OUT_VALID of a captured frame
- OUT_EOF  out  1  one-cycle pulse at the end of a captured frame
- BUSY  out  1  state is not IDLE
- FRAME_DONE, FRAME_ERR, TIMEOUT  out  1 each  one-cycle status pulses
- FRAME_CNT  out  16  captured frames, wraps at 65535 -> 0

## Operation
- Edge detection uses pre_FVAL/pre_LVAL registers. Rise = FVAL & ~pre_FVAL; fall = ~FVAL & pre_FVAL; line end = ~LVAL & pre_LVAL.
- **IDLE**
  - CMD_VALID & CMD_READY latches mode, skip and skip_rem = CMD_SKIP, then moves to ARMED.
  - CMD_STOP is ignored in IDLE.
- **ARMED**
  - On rise with skip_rem == 0: go to CAPTURE. The rise cycle itself is a capture cycle.
  - On rise with skip_rem != 0: decrement skip_rem and ignore that frame.
  - If armed mid-frame, the partial frame is never captured because capture begins only on a rise.
  - CMD_STOP: go to IDLE on the next cycle.
- **CAPTURE**
  - Each cycle: OUT_VALID <= FVAL & LVAL and OUT_DATA <= CAMERA_D.
  - Pixel counter increments on FVAL & LVAL and saturates at 4095.
  - At each line end: if the pixel count != EXP_WIDTH, set sticky err; then clear the pixel count and increment the line count (saturates at 4095).
  - On fall:
    - if line count != EXP_HEIGHT, set err;
    - pulse OUT_EOF and FRAME_DONE;
    - pulse FRAME_ERR if err is set;
    - increment FRAME_CNT;
    - clear the counters and err.
  - Next state after fall: ARMED (skip_rem reloaded) if mode = 1 and no stop is latched; otherwise IDLE.
  - CMD_STOP seen in CAPTURE is latched. The current frame completes, then the block returns to IDLE.
- A command is never accepted outside IDLE. CMD_VALID held across frame end is accepted in the first IDLE cycle.
- Rise and fall cannot coincide. A fall in the same cycle as CMD_STOP still completes the frame normally.

## Timing
- OUT_DATA, OUT_VALID and OUT_SOF lag CAMERA_D and the syncs by exactly 1 cycle.
- OUT_EOF, FRAME_DONE, FRAME_ERR and the state change are registered 1 cycle after the fall-detect cycle.
- CMD_READY and BUSY decode the state register, so they take 0 cycles from a state change.
- Reset values:
  - state = IDLE;
  - all outputs 0 except CMD_READY = 1;
  - FRAME_CNT = 0;
  - skip_rem, counters, err, stop-latch and pre_* registers = 0.
- Reset asserted mid-capture drops the frame immediately. No OUT_EOF or FRAME_DONE is issued.

## Configuration
- `CAMERA_FRAME_SCHED_TIMEOUT_EN` defined:
  - a 24-bit watchdog counts every cycle in ARMED and CAPTURE and clears on any FVAL edge;
  - on reaching TIMEOUT_CYCLES it pulses TIMEOUT, drops OUT_VALID and returns to IDLE without FRAME_DONE;
  - counters and err are cleared.
- Macro undefined: no watchdog logic is built and TIMEOUT is tied to 0.

## Structure
- Package camera_sched_pkg holds:
  - the state enum (IDLE, ARMED, CAPTURE);
  - the CMD_MODE constants (MODE_SINGLE = 0, MODE_CONT = 1);
  - the 12-bit pixel/line count width.
- One sub-module, camera_frame_measure:
  - contains the pixel/line counters, saturation and the sticky err compare;
  - inputs: clear, FVAL & LVAL, line-end, frame-end;
  - outputs: err.

## Test plan
- Single, skip 0, EXP 8x4, two clean 8x4 frames → the first frame is forwarded as 32 OUT_VALID with one OUT_SOF, then one FRAME_DONE, FRAME_CNT = 1, IDLE. The second frame is not forwarded.
- Continuous, skip 2, six frames → frames 3 and 6 are captured and FRAME_CNT = 2. CMD_STOP raised during frame 6 gives IDLE after its OUT_EOF.
- Command accepted mid-frame → that partial frame is dropped and capture starts on the next rise.
- Capture a frame with line 2 at 7 pixels, then one with 5 lines → FRAME_ERR pulses with FRAME_DONE for each, and err does not carry into a following clean frame.
- Reset pulsed mid-capture → all outputs at reset values next cycle, with no OUT_EOF.
- With the macro and TIMEOUT_CYCLES = 100, arm with FVAL held low → TIMEOUT pulses on cycle 100 and CMD_READY returns to 1.
